// File: rtl/dmem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arb_pkg
// Description : Shared types and access-size codes for the data-memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_arb_pkg;

    localparam int DMEM_AW = 9;
    localparam int DMEM_DW = 32;

    typedef enum logic {
        PORT_C = 1'b0,
        PORT_D = 1'b1
    } port_e;

    typedef struct packed {
        logic               we;
        logic [DMEM_AW-1:0] addr;
        logic [DMEM_DW-1:0] wd;
        logic [2:0]         funct3;
    } dmem_req_t;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

endpackage : dmem_arb_pkg
`default_nettype wire

// File: rtl/dmem_arb_sel.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arb_sel
// Description : Combinational grant selection between core (C) and loader (D).
//               DMEM_ARB_RR_EN selects round-robin, otherwise fixed priority
//               with a starvation guard on D.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_arb_sel
    import dmem_arb_pkg::*;
`ifndef DMEM_ARB_RR_EN
#(
    parameter int WAIT_W   = 3,
    parameter int MAX_WAIT = 7
)
`endif
(
    input  logic              c_req,
    input  logic              d_req,
`ifdef DMEM_ARB_RR_EN
    input  port_e             last_grant,
`else
    input  logic [WAIT_W-1:0] wait_cnt,
`endif
    output logic              gnt_valid,
    output port_e             gnt_port
);

`ifdef DMEM_ARB_RR_EN
    always_comb begin
        gnt_valid = c_req | d_req;
        gnt_port  = PORT_C;
        // On a tie the port that was not served last goes first.
        if (d_req && (!c_req || (last_grant == PORT_C))) begin
            gnt_port = PORT_D;
        end
    end
`else
    localparam logic [WAIT_W-1:0] c_wait_max = WAIT_W'(MAX_WAIT);

    logic w_force_d;

    assign w_force_d = d_req && (wait_cnt == c_wait_max);

    always_comb begin
        gnt_valid = c_req | d_req;
        gnt_port  = PORT_C;
        if (d_req && (w_force_d || !c_req)) begin
            gnt_port = PORT_D;
        end
    end
`endif

endmodule : dmem_arb_sel
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter
// Description : Shares the single-port data memory between the MEM stage (C)
//               and a loader/DMA port (D); one access per cycle, registered
//               read data. Build macro DMEM_ARB_RR_EN enables round-robin.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32,
    parameter int MAX_WAIT   = 7
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  c_req,
    input  logic                  c_we,
    input  logic [DM_ADDRESS-1:0] c_addr,
    input  logic [DATA_W-1:0]     c_wd,
    input  logic [2:0]            c_funct3,
    output logic                  c_gnt,
    output logic                  c_rvalid,
    output logic [DATA_W-1:0]     c_rd,

    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [DM_ADDRESS-1:0] d_addr,
    input  logic [DATA_W-1:0]     d_wd,
    input  logic [2:0]            d_funct3,
    output logic                  d_gnt,
    output logic                  d_rvalid,
    output logic [DATA_W-1:0]     d_rd,

    output logic                  m_MemRead,
    output logic                  m_MemWrite,
    output logic [DM_ADDRESS-1:0] m_a,
    output logic [DATA_W-1:0]     m_wd,
    output logic [2:0]            m_Funct3,
    input  logic [DATA_W-1:0]     m_rd
);

    // The request struct in the package is sized for the default geometry.
    generate
        if (DM_ADDRESS != DMEM_AW || DATA_W != DMEM_DW || MAX_WAIT < 1) begin : g_param_check
            $error("dmem_arbiter: unsupported parameter set");
        end
    endgenerate

    dmem_req_t w_c_fields;
    dmem_req_t w_d_fields;
    dmem_req_t w_sel;
    logic      w_sel_valid;
    port_e     w_sel_port;
    logic      w_gnt_valid;
    logic      w_c_rd_gnt;
    logic      w_d_rd_gnt;

    logic              r_c_rvalid;
    logic              r_d_rvalid;
    logic [DATA_W-1:0] r_c_rd;
    logic [DATA_W-1:0] r_d_rd;

`ifdef DMEM_ARB_RR_EN
    port_e r_last_grant;

    dmem_arb_sel u_sel (
        .c_req      (c_req),
        .d_req      (d_req),
        .last_grant (r_last_grant),
        .gnt_valid  (w_sel_valid),
        .gnt_port   (w_sel_port)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_grant <= PORT_D;
        end else if (w_gnt_valid) begin
            r_last_grant <= w_sel_port;
        end
    end
`else
    localparam int c_wait_w = $clog2(MAX_WAIT + 1);
    localparam logic [c_wait_w-1:0] c_wait_max = c_wait_w'(MAX_WAIT);

    logic [c_wait_w-1:0] r_wait_cnt;

    dmem_arb_sel #(
        .WAIT_W   (c_wait_w),
        .MAX_WAIT (MAX_WAIT)
    ) u_sel (
        .c_req     (c_req),
        .d_req     (d_req),
        .wait_cnt  (r_wait_cnt),
        .gnt_valid (w_sel_valid),
        .gnt_port  (w_sel_port)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wait_cnt <= '0;
        end else if (!d_req || d_gnt) begin
            r_wait_cnt <= '0;
        end else if (r_wait_cnt != c_wait_max) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
        end
    end
`endif

    assign w_c_fields = '{we: c_we, addr: c_addr, wd: c_wd, funct3: c_funct3};
    assign w_d_fields = '{we: d_we, addr: d_addr, wd: d_wd, funct3: d_funct3};

    // No memory access is issued while reset is held.
    assign w_gnt_valid = w_sel_valid & ~reset;
    assign c_gnt       = w_gnt_valid & (w_sel_port == PORT_C);
    assign d_gnt       = w_gnt_valid & (w_sel_port == PORT_D);

    always_comb begin
        w_sel = '0;
        if (c_gnt) begin
            w_sel = w_c_fields;
        end else if (d_gnt) begin
            w_sel = w_d_fields;
        end
    end

    assign m_MemRead  = w_gnt_valid & ~w_sel.we;
    assign m_MemWrite = w_gnt_valid &  w_sel.we;
    assign m_a        = w_sel.addr;
    assign m_wd       = w_sel.wd;
    assign m_Funct3   = w_sel.funct3;

    assign w_c_rd_gnt = c_gnt & ~c_we;
    assign w_d_rd_gnt = d_gnt & ~d_we;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_c_rvalid <= 1'b0;
            r_d_rvalid <= 1'b0;
            r_c_rd     <= '0;
            r_d_rd     <= '0;
        end else begin
            r_c_rvalid <= w_c_rd_gnt;
            r_d_rvalid <= w_d_rd_gnt;
            if (w_c_rd_gnt) begin
                r_c_rd <= m_rd;
            end
            if (w_d_rd_gnt) begin
                r_d_rd <= m_rd;
            end
        end
    end

    // A response in flight when reset arrives is discarded immediately.
    assign c_rvalid = r_c_rvalid & ~reset;
    assign d_rvalid = r_d_rvalid & ~reset;
    assign c_rd     = reset ? '0 : r_c_rd;
    assign d_rd     = reset ? '0 : r_d_rd;

endmodule : dmem_arbiter
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_arbiter
// Description : Directed self-checking bench for dmem_arbiter with a small
//               byte-addressed data-memory model on the m_* side.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

    logic        clk;
    logic        reset;
    logic        c_req, c_we, c_gnt, c_rvalid;
    logic [8:0]  c_addr;
    logic [31:0] c_wd, c_rd;
    logic [2:0]  c_funct3;
    logic        d_req, d_we, d_gnt, d_rvalid;
    logic [8:0]  d_addr;
    logic [31:0] d_wd, d_rd;
    logic [2:0]  d_funct3;
    logic        m_MemRead, m_MemWrite;
    logic [8:0]  m_a;
    logic [31:0] m_wd, m_rd;
    logic [2:0]  m_Funct3;

    int errors = 0;
    int checks = 0;

    dmem_arbiter #(
        .DM_ADDRESS (9),
        .DATA_W     (32),
        .MAX_WAIT   (7)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .c_req      (c_req),
        .c_we       (c_we),
        .c_addr     (c_addr),
        .c_wd       (c_wd),
        .c_funct3   (c_funct3),
        .c_gnt      (c_gnt),
        .c_rvalid   (c_rvalid),
        .c_rd       (c_rd),
        .d_req      (d_req),
        .d_we       (d_we),
        .d_addr     (d_addr),
        .d_wd       (d_wd),
        .d_funct3   (d_funct3),
        .d_gnt      (d_gnt),
        .d_rvalid   (d_rvalid),
        .d_rd       (d_rd),
        .m_MemRead  (m_MemRead),
        .m_MemWrite (m_MemWrite),
        .m_a        (m_a),
        .m_wd       (m_wd),
        .m_Funct3   (m_Funct3),
        .m_rd       (m_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data memory model: little-endian words, sign/zero-extending loads.
    logic [31:0] mem [0:127];
    logic [31:0] w_word;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_word = mem[m_a[8:2]];
        w_byte = w_word[{m_a[1:0], 3'b000} +: 8];
        w_half = w_word[{m_a[1], 4'b0000} +: 16];
        m_rd   = '0;
        case (m_Funct3)
            3'b000:  m_rd = {{24{w_byte[7]}}, w_byte};
            3'b001:  m_rd = {{16{w_half[15]}}, w_half};
            3'b010:  m_rd = w_word;
            3'b100:  m_rd = {24'd0, w_byte};
            3'b101:  m_rd = {16'd0, w_half};
            default: m_rd = w_word;
        endcase
    end

    always @(posedge clk) begin
        if (m_MemWrite) begin
            case (m_Funct3[1:0])
                2'b00:   mem[m_a[8:2]][{m_a[1:0], 3'b000} +: 8] <= m_wd[7:0];
                2'b01:   mem[m_a[8:2]][{m_a[1], 4'b0000} +: 16] <= m_wd[15:0];
                default: mem[m_a[8:2]] <= m_wd;
            endcase
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 32'h0;
        mem[0] = 32'h8000_0000;

        reset = 1'b1;
        c_req = 1'b0; c_we = 1'b0; c_addr = '0; c_wd = '0; c_funct3 = 3'b010;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wd = '0; d_funct3 = 3'b010;

        // Reset, no requests
        for (int i = 0; i < 3; i++) cyc();
        chk("rst_c_gnt",    32'(c_gnt), 32'd0);
        chk("rst_d_gnt",    32'(d_gnt), 32'd0);
        chk("rst_c_rvalid", 32'(c_rvalid), 32'd0);
        chk("rst_d_rvalid", 32'(d_rvalid), 32'd0);
        chk("rst_memrd",    32'(m_MemRead), 32'd0);
        chk("rst_memwr",    32'(m_MemWrite), 32'd0);
        chk("rst_c_rd",     c_rd, 32'd0);
        chk("rst_d_rd",     d_rd, 32'd0);
        reset = 1'b0;
        cyc();
        chk("idle_m_a",     32'(m_a), 32'd0);

        // C alone: SW then LW at 0x010
        c_req = 1'b1; c_we = 1'b1; c_addr = 9'h010; c_wd = 32'hDEAD_BEEF; c_funct3 = 3'b010;
        #1;
        chk("c_wr_gnt",   32'(c_gnt), 32'd1);
        chk("c_wr_memwr", 32'(m_MemWrite), 32'd1);
        chk("c_wr_memrd", 32'(m_MemRead), 32'd0);
        chk("c_wr_m_a",   32'(m_a), 32'h010);
        chk("c_wr_m_wd",  m_wd, 32'hDEAD_BEEF);
        cyc();
        c_we = 1'b0; c_wd = '0;
        #1;
        chk("c_rd_gnt",      32'(c_gnt), 32'd1);
        chk("c_rd_memrd",    32'(m_MemRead), 32'd1);
        chk("c_wr_no_rvalid", 32'(c_rvalid), 32'd0);
        cyc();
        c_req = 1'b0;
        #1;
        chk("c_rvalid",      32'(c_rvalid), 32'd1);
        chk("c_rd_data",     c_rd, 32'hDEAD_BEEF);
        chk("c_rd_d_rvalid", 32'(d_rvalid), 32'd0);
        chk("c_idle_memrd",  32'(m_MemRead), 32'd0);
        cyc();
        chk("c_rvalid_drop", 32'(c_rvalid), 32'd0);
        chk("c_rd_hold",     c_rd, 32'hDEAD_BEEF);

        // D alone: LB at 0x003 (byte 0x80)
        d_req = 1'b1; d_we = 1'b0; d_addr = 9'h003; d_funct3 = 3'b000;
        #1;
        chk("d_lb_gnt",    32'(d_gnt), 32'd1);
        chk("d_lb_c_gnt",  32'(c_gnt), 32'd0);
        chk("d_lb_f3",     32'(m_Funct3), 32'd0);
        chk("d_lb_m_a",    32'(m_a), 32'h003);
        cyc();
        d_req = 1'b0;
        #1;
        chk("d_rvalid",      32'(d_rvalid), 32'd1);
        chk("d_rd_data",     d_rd, 32'hFFFF_FF80);
        chk("d_rd_c_rvalid", 32'(c_rvalid), 32'd0);
        chk("d_rd_c_hold",   c_rd, 32'hDEAD_BEEF);

        // Reset arriving while a read response is pending
        cyc();
        c_req = 1'b1; c_we = 1'b0; c_addr = 9'h010; c_funct3 = 3'b010;
        #1;
        chk("rr_pre_gnt", 32'(c_gnt), 32'd1);
        cyc();
        c_req = 1'b0; reset = 1'b1;
        #1;
        chk("rstmid_c_rvalid", 32'(c_rvalid), 32'd0);
        chk("rstmid_d_rvalid", 32'(d_rvalid), 32'd0);
        chk("rstmid_c_rd",     c_rd, 32'd0);
        chk("rstmid_d_rd",     d_rd, 32'd0);
        cyc();
        reset = 1'b0;
        cyc();
        chk("rstpost_c_rvalid", 32'(c_rvalid), 32'd0);
        chk("rstpost_c_rd",     c_rd, 32'd0);

        // Both requesting continuously
        c_req = 1'b1; c_we = 1'b0; c_addr = 9'h010; c_funct3 = 3'b010;
        d_req = 1'b1; d_we = 1'b0; d_addr = 9'h003; d_funct3 = 3'b000;
`ifdef DMEM_ARB_RR_EN
        for (int i = 0; i < 8; i++) begin
            #1;
            chk("rr_c_gnt", 32'(c_gnt), 32'((i % 2) == 0));
            chk("rr_d_gnt", 32'(d_gnt), 32'((i % 2) == 1));
            cyc();
        end
`else
        for (int i = 0; i < 16; i++) begin
            #1;
            chk("fp_c_gnt",    32'(c_gnt), 32'((i % 8) != 7));
            chk("fp_d_gnt",    32'(d_gnt), 32'((i % 8) == 7));
            chk("fp_c_rvalid", 32'(c_rvalid), 32'((i >= 1) && (i != 8)));
            chk("fp_d_rvalid", 32'(d_rvalid), 32'(i == 8));
            cyc();
        end
        // D dropping its request clears the accumulated wait
        for (int i = 0; i < 3; i++) cyc();
        d_req = 1'b0;
        #1;
        chk("drop_d_gnt", 32'(d_gnt), 32'd0);
        cyc();
        d_req = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk("drop_wait_d_gnt", 32'(d_gnt), 32'(i == 7));
            cyc();
        end
`endif
        c_req = 1'b0; d_req = 1'b0;
        cyc();
        chk("end_idle_memrd", 32'(m_MemRead), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_dmem_arbiter
`default_nettype wire
